// File: rtl/no_generic.sv
// Boolean network node: evaluates one gene's truth-table update function over
// NUM_TRAJ independent trajectories, each with its own update divider and
// steady-state detector.
module no_generic #(
  parameter int unsigned           NUM_IN    = 5,
  parameter int unsigned           NUM_TRAJ  = 2,
  parameter logic [2**NUM_IN-1:0]  TT        = 32'hFFFFFEEE,
  parameter int unsigned           DIV_W     = 4,
  parameter int unsigned           STAB_W    = 8,
  parameter int unsigned           STABLE_TH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reset_nos,
  input  logic [NUM_TRAJ-1:0]          init_state,
  input  logic [NUM_TRAJ-1:0]          start,
  input  logic [NUM_TRAJ*DIV_W-1:0]    div,
  input  logic [NUM_TRAJ*NUM_IN-1:0]   in_bits,
  output logic [NUM_TRAJ-1:0]          s,
  output logic [NUM_TRAJ-1:0]          changed,
  output logic [NUM_TRAJ-1:0]          stable,
  output logic [NUM_TRAJ-1:0]          upd
);

  for (genvar t = 0; t < NUM_TRAJ; t++) begin : g_traj
    logic              s_q, s_d;
    logic              chg_q, chg_d;
    logic              upd_q, upd_d;
    logic [DIV_W-1:0]  ph_q, ph_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [DIV_W-1:0]  div_t;
    logic [DIV_W-1:0]  per_m1;
    logic [NUM_IN-1:0] idx;
    logic              nxt;

    assign div_t  = div[t*DIV_W +: DIV_W];
    // div of 0 and 1 both mean "every start", so the wrap point is 0 for both.
    assign per_m1 = (div_t == '0) ? '0 : div_t - 1'b1;
    assign idx    = in_bits[t*NUM_IN +: NUM_IN];
    assign nxt    = TT[idx];

    // Next-state: reload, evaluate on phase 0, skip otherwise, advance phase.
    always_comb begin
      s_d    = s_q;
      ph_d   = ph_q;
      stab_d = stab_q;
      chg_d  = 1'b0;
      upd_d  = 1'b0;
      if (reset_nos) begin
        s_d    = init_state[t];
        ph_d   = '0;
        stab_d = '0;
      end else if (start[t]) begin
        if (ph_q == '0) begin
          s_d   = nxt;
          upd_d = 1'b1;
          chg_d = (nxt != s_q);
          if (nxt == s_q) begin
            stab_d = (stab_q == '1) ? stab_q : stab_q + 1'b1;
          end else begin
            stab_d = '0;
          end
        end
        // >= so a shrunken divider wraps immediately instead of running out.
        ph_d = (ph_q >= per_m1) ? '0 : ph_q + 1'b1;
      end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s_q    <= 1'b0;
        ph_q   <= '0;
        stab_q <= '0;
        chg_q  <= 1'b0;
        upd_q  <= 1'b0;
      end else begin
        s_q    <= s_d;
        ph_q   <= ph_d;
        stab_q <= stab_d;
        chg_q  <= chg_d;
        upd_q  <= upd_d;
      end
    end

    assign s[t]       = s_q;
    assign changed[t] = chg_q;
    assign upd[t]     = upd_q;
    assign stable[t]  = (stab_q >= STAB_W'(STABLE_TH));
  end

endmodule

// File: tb/tb_no_generic.sv
// Self-checking bench for no_generic with default parameters (K=5, T=2).
module tb_no_generic;

  localparam logic [31:0] TtRef = 32'hFFFFFEEE;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset_nos;
  logic [1:0] init_state;
  logic [1:0] start;
  logic [7:0] div;
  logic [9:0] in_bits;
  logic [1:0] s, changed, stable, upd;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [1:0] m_s, m_chg, m_upd;
  int         m_ph[2];
  int         m_stab[2];

  logic [7:0] exp_q[$];

  no_generic dut (
    .clk       (clk),
    .rst       (rst),
    .reset_nos (reset_nos),
    .init_state(init_state),
    .start     (start),
    .div       (div),
    .in_bits   (in_bits),
    .s         (s),
    .changed   (changed),
    .stable    (stable),
    .upd       (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s = '0; m_chg = '0; m_upd = '0;
    for (int t = 0; t < 2; t++) begin
      m_ph[t] = 0;
      m_stab[t] = 0;
    end
  endtask

  function automatic logic [1:0] model_stable();
    logic [1:0] r;
    for (int t = 0; t < 2; t++) r[t] = (m_stab[t] >= 4);
    return r;
  endfunction

  task automatic model_step(input logic rn, input logic [1:0] init, input logic [1:0] st,
                            input logic [7:0] dv, input logic [9:0] ib);
    for (int t = 0; t < 2; t++) begin
      int   p;
      logic nxt;
      m_chg[t] = 1'b0;
      m_upd[t] = 1'b0;
      if (rn) begin
        m_s[t]    = init[t];
        m_ph[t]   = 0;
        m_stab[t] = 0;
      end else if (st[t]) begin
        p = int'(dv[t*4 +: 4]);
        if (p == 0) p = 1;
        if (m_ph[t] == 0) begin
          nxt      = TtRef[ib[t*5 +: 5]];
          m_upd[t] = 1'b1;
          m_chg[t] = (nxt != m_s[t]);
          if (nxt == m_s[t]) m_stab[t] = (m_stab[t] < 255) ? m_stab[t] + 1 : 255;
          else               m_stab[t] = 0;
          m_s[t] = nxt;
        end
        m_ph[t] = (m_ph[t] >= p - 1) ? 0 : m_ph[t] + 1;
      end
    end
  endtask

  // One clock: drive, predict into the scoreboard, then compare after the edge.
  task automatic step(input logic rn, input logic [1:0] init, input logic [1:0] st,
                      input logic [7:0] dv, input logic [9:0] ib);
    reset_nos  = rn;
    init_state = init;
    start      = st;
    div        = dv;
    in_bits    = ib;
    model_step(rn, init, st, dv, ib);
    exp_q.push_back({m_s, m_chg, m_upd, model_stable()});
    @(posedge clk);
    #1;
    check("step", {24'd0, s, changed, upd, stable}, {24'd0, exp_q.pop_front()});
  endtask

  initial begin
    rst = 1'b0; reset_nos = 1'b0; init_state = '0; start = '0; div = '0; in_bits = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", s, 2'b00);
    check("rst_changed", changed, 2'b00);
    check("rst_stable", stable, 2'b00);
    check("rst_upd", upd, 2'b00);
    rst = 1'b1;

    // Legacy equivalence: t0 div=2, t1 div=1.
    step(1, 2'b00, 2'b00, {4'd1, 4'd2}, {5'b00001, 5'b00001});
    step(0, 2'b00, 2'b11, {4'd1, 4'd2}, {5'b00001, 5'b00001});
    check("leg1_s", s, 2'b11);
    check("leg1_chg", changed, 2'b11);
    check("leg1_upd", upd, 2'b11);
    step(0, 2'b00, 2'b11, {4'd1, 4'd2}, {5'b00001, 5'b00001});
    check("leg2_chg", changed, 2'b00);
    check("leg2_upd", upd, 2'b10);
    step(0, 2'b00, 2'b11, {4'd1, 4'd2}, {5'b00001, 5'b00001});
    check("leg3_upd", upd, 2'b11);
    check("leg3_chg", changed, 2'b00);
    step(0, 2'b00, 2'b11, {4'd1, 4'd2}, {5'b00001, 5'b00001});
    check("leg4_upd", upd, 2'b10);
    check("leg4_s", s, 2'b11);

    // Truth-table corners on trajectory 0.
    step(1, 2'b00, 2'b00, 8'h11, 10'd0);
    step(0, 2'b00, 2'b01, 8'h11, {5'd0, 5'd0});
    check("tt0", s[0], 1'b0);
    step(0, 2'b00, 2'b01, 8'h11, {5'd0, 5'd4});
    check("tt4", s[0], 1'b0);
    step(0, 2'b00, 2'b01, 8'h11, {5'd0, 5'd8});
    check("tt8", s[0], 1'b0);
    step(0, 2'b00, 2'b01, 8'h11, {5'd0, 5'd12});
    check("tt12", s[0], 1'b1);
    for (int i = 0; i < 32; i++) begin
      step(0, 2'b00, 2'b11, 8'h11, {5'(31 - i), 5'(i)});
    end

    // Stability: s0 starts at 1, input 5'b10000 keeps it there.
    step(1, 2'b01, 2'b00, 8'h11, 10'd0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 2'b00, 2'b01, 8'h11, {5'd0, 5'b10000});
      check("stab_rise", stable[0], (k == 4) ? 1'b1 : 1'b0);
    end
    step(0, 2'b00, 2'b01, 8'h11, {5'd0, 5'b10000});
    check("stab_hold", stable[0], 1'b1);
    step(0, 2'b00, 2'b01, 8'h11, {5'd0, 5'd0});
    check("stab_chg", changed[0], 1'b1);
    check("stab_drop", stable[0], 1'b0);

    // Precedence of reset_nos over start, from a mid-phase position.
    step(1, 2'b00, 2'b00, 8'h22, 10'd0);
    step(0, 2'b00, 2'b11, 8'h22, {5'd1, 5'd1});
    step(1, 2'b10, 2'b11, 8'h22, {5'd1, 5'd1});
    check("prec_s", s, 2'b10);
    check("prec_upd", upd, 2'b00);
    step(0, 2'b00, 2'b11, 8'h22, {5'd0, 5'd0});
    check("prec_next_upd", upd, 2'b11);

    // Divider shrink: div=5 up to ph=3, then div=2 wraps without evaluating.
    step(1, 2'b00, 2'b00, 8'h15, 10'd0);
    for (int k = 0; k < 3; k++) step(0, 2'b00, 2'b01, 8'h15, {5'd0, 5'd1});
    step(0, 2'b00, 2'b01, 8'h12, {5'd0, 5'd1});
    check("div_wrap_upd", upd[0], 1'b0);
    step(0, 2'b00, 2'b01, 8'h12, {5'd0, 5'd1});
    check("div_eval_upd", upd[0], 1'b1);

    // div=0 on t0 against div=1 on t1.
    step(1, 2'b00, 2'b00, 8'h10, 10'd0);
    for (int k = 0; k < 4; k++) begin
      step(0, 2'b00, 2'b11, 8'h10, {5'(k * 3), 5'(k * 3)});
      check("div0_upd", upd, 2'b11);
      check("div0_s", {1'b0, s[0]}, {1'b0, s[1]});
    end

    // Asynchronous reset between edges while start is high.
    step(0, 2'b00, 2'b11, 8'h11, {5'd1, 5'd1});
    #3 rst = 1'b0;
    #1;
    check("arst_s", s, 2'b00);
    check("arst_chg", changed, 2'b00);
    check("arst_stable", stable, 2'b00);
    check("arst_upd", upd, 2'b00);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    step(0, 2'b00, 2'b11, 8'h22, {5'd1, 5'd1});
    check("arst_first_upd", upd, 2'b11);
    check("arst_first_s", s, 2'b11);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/no_generic.md
# no_generic

Parametrised Boolean network node for the GNR simulation array. It evaluates one gene's update function, given as a truth table, over NUM_TRAJ independent trajectories in parallel. Each trajectory has its own programmable update divider, which generalises the fixed "update every other start" scheme, and a steady-state detector. It sits in the node array between the neighbour-state fan-in and the controller that issues per-trajectory start strobes.

## Interface
- NUM_IN, 5: inputs to the Boolean function (K); legal range 1..6.
- NUM_TRAJ, 2: parallel trajectories (T); legal range ≥1.
- TT, 32'hFFFFFEEE: truth table, 2^K bits; bit i = next state when the input vector equals i. The default is in0|in1|(in2&in3)|in4.
- DIV_W, 4: width of each per-trajectory divider value.
- STAB_W, 8: width of the saturating stability counter.
- STABLE_TH, 4: number of consecutive unchanged updates needed to assert stable; must be ≤ 2^STAB_W−1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- reset_nos  in  1  synchronous reload of all trajectories from init_state.
- init_state  in  T  reload value per trajectory.
- start  in  T  per-trajectory update strobe.
- div  in  T*DIV_W  update period per trajectory; trajectory t uses bits [t*DIV_W +: DIV_W]. Values 0 and 1 both mean "every start".
- in_bits  in  T*K  function inputs; trajectory t uses bits [t*K +: K], with input 0 at the LSB.
- s  out  T  registered node state.
- changed  out  T  one-cycle pulse: the last update altered s.
- stable  out  T  high when stab_cnt[t] ≥ STABLE_TH.
- upd  out  T  one-cycle pulse: an evaluation occurred for that trajectory.

## Operation
Per trajectory t, the block holds s[t], a phase counter ph[t] (DIV_W bits) and stab_cnt[t] (STAB_W bits). Trajectories are fully independent.

- **Async reset (rst=0):** s=0, ph=0, stab_cnt=0, changed=0, upd=0. The first start after reset therefore evaluates.
- **reset_nos=1:**
  - Applies to all trajectories.
  - s[t] ← init_state[t]; ph ← 0; stab_cnt ← 0; changed ← 0; upd ← 0.
  - Overrides start in the same cycle.
- **start[t]=1 with reset_nos=0:** let P = max(div[t], 1).
  - If ph[t]==0, evaluate: nxt = TT[in_bits_t], s[t] ← nxt, upd[t] ← 1, changed[t] ← (nxt≠s[t]).
    - If nxt==s[t], stab_cnt increments and saturates at all-ones.
    - Otherwise stab_cnt ← 0.
  - If ph[t]≠0, it is a skip: s and stab_cnt hold, upd=0, changed=0.
  - Phase update: ph[t] ← (ph[t] ≥ P−1) ? 0 : ph[t]+1.
  - The ≥ compare means that shrinking div mid-run wraps the phase to 0 immediately, with no long run-out.
- **start[t]=0:** all state holds; changed and upd drop to 0.
- **Sampling:** div is sampled on every start, so it may change between starts.
- **Compatibility:** div=2 reproduces the legacy s0 behaviour (evaluate, skip, evaluate, …, after each reload). div=1 reproduces s1.

## Timing
- Latency: s, changed and upd reflect a start on the rising edge where start is sampled high, and are visible in the following cycle.
- stable is combinational from stab_cnt. It rises in the cycle after the STABLE_TH-th consecutive unchanged evaluation.
- start may be held high continuously; every clock with start high counts as one strobe.
- in_bits must be stable in the cycle start is high. No other handshake exists.
- rst deassertion must be synchronous to clk, which is guaranteed by the system reset bridge. Assertion takes effect immediately.
- Reset values of all outputs: s=0, changed=0, stable=0, upd=0.

## Test plan
- **Legacy equivalence:** default parameters, div={1,2}. Apply reset_nos with init_state=2'b00, then four starts on both trajectories with in_bits = 5'b00001 each.
  - Trajectory 1 updates on every start; trajectory 0 updates on starts 1 and 3.
  - s goes to 2'b11 after the first start.
  - changed pulses on the first start only, on both trajectories.
  - upd[0] pulses on starts 1 and 3; upd[1] pulses on all four.
- **Truth-table corners:** trajectory 0, in_bits ∈ {0,4,8,12}.
  - Inputs 0, 4 and 8 give s=0; input 12 gives s=1.
  - Also sweep all 32 inputs against TT.
- **Stability:** hold in_bits=5'b10000 from s=1 with div=1.
  - stable rises one cycle after the 4th unchanged evaluation.
  - Switching in_bits to 0 gives changed=1, stab_cnt=0 and stable=0 on the next cycle.
- **Precedence:** assert reset_nos and start together with init_state=2'b10.
  - Result is s=2'b10, upd=0 and ph=0; the next start evaluates.
- **Divider change:** run div=5 until ph=3, then set div=2 and pulse start.
  - ph wraps to 0 with no evaluation; the next start evaluates.
  - div=0 behaves exactly like div=1.
- **Async reset mid-run:** drop rst between clock edges while start is high.
  - s, changed, stable and upd all read 0 immediately.
  - After release, the first start evaluates.
